// File: rtl/col_lane_serializer.sv
// Captures a CH-lane plane in one cycle and emits it one lane per beat on a valid/ready stream.
// Optional COL_ROTATE_START_EN adds a start_idx port selecting the first emitted lane.
//
// state | meaning
// IDLE  | no plane held, load accepted
// SEND  | plane held, presenting lane[idx] until CH beats have transferred
module col_lane_serializer #(
    parameter int N  = 5,
    parameter int CH = 5,
    localparam int SELW = $clog2(CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CH*N-1:0]   in_bus,
`ifdef COL_ROTATE_START_EN
    input  logic [SELW-1:0]   start_idx,
`endif
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic [SELW-1:0]   out_idx,
    output logic              out_last
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [SELW-1:0] LAST = SELW'(CH - 1);

    state_t              state;
    logic [CH*N-1:0]     plane;
    logic [SELW-1:0]     idx;
    logic [SELW-1:0]     cnt;
    logic [SELW-1:0]     first_idx;
    logic [SELW-1:0]     next_idx;

    always_comb begin
        first_idx = '0;
`ifdef COL_ROTATE_START_EN
        // Out-of-range start lanes fall back to lane 0.
        first_idx = (start_idx > LAST) ? '0 : start_idx;
`endif
        next_idx = (idx == LAST) ? '0 : idx + 1'b1;
    end

    assign busy      = (state == SEND);
    assign out_valid = (state == SEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            plane    <= '0;
            idx      <= '0;
            cnt      <= '0;
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state    <= SEND;
                        plane    <= in_bus;
                        idx      <= first_idx;
                        cnt      <= '0;
                        out_data <= in_bus[first_idx*N +: N];
                        out_idx  <= first_idx;
                        out_last <= 1'b0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        idx <= next_idx;
                        if (cnt == LAST) begin
                            // Final beat: outputs return to their idle values.
                            state    <= IDLE;
                            cnt      <= '0;
                            out_data <= '0;
                            out_idx  <= '0;
                            out_last <= 1'b0;
                        end else begin
                            cnt      <= cnt + 1'b1;
                            out_data <= plane[next_idx*N +: N];
                            out_idx  <= next_idx;
                            out_last <= ((cnt + 1'b1) == LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_col_lane_serializer.sv
// Scoreboard bench for col_lane_serializer: driver queues expected beats per plane, monitor pops on transfer.
module tb_col_lane_serializer;

    localparam int N    = 5;
    localparam int CH   = 5;
    localparam int SELW = $clog2(CH);
    localparam int W    = N + SELW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic              out_ready = 1'b0;
    logic [CH*N-1:0]   in_bus = '0;
    logic [SELW-1:0]   start_idx = '0;
    logic              busy, out_valid, out_last;
    logic [N-1:0]      out_data;
    logic [SELW-1:0]   out_idx;

    always #5 clk = ~clk;

    col_lane_serializer #(.N(N), .CH(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .in_bus    (in_bus),
`ifdef COL_ROTATE_START_EN
        .start_idx (start_idx),
`endif
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] sb[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    bit           exp_busy;
    bit           stall_q = 1'b0;
    logic [W-1:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {busy, out_valid, out_data, out_idx, out_last}, '0);
            stall_q = 1'b0;
        end else begin
            exp_busy = (sb.size() > 0);
            check("busy", busy, exp_busy);
            check("out_valid", out_valid, exp_busy);
            if (!out_valid) check("idle_last", out_last, 0);
            if (stall_q) check("stall_hold", {out_data, out_idx, out_last}, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_beat: got data %0h idx %0d expected no beat", out_data, out_idx);
                end else begin
                    check("beat", {out_data, out_idx, out_last}, sb.pop_front());
                end
            end
            stall_q = out_valid && !out_ready;
            held    = {out_data, out_idx, out_last};
        end
    end

    // Reference: CH beats in ascending cyclic order from the start lane.
    task automatic push_plane(logic [CH*N-1:0] d, logic [SELW-1:0] sidx);
        int s;
        s = 0;
`ifdef COL_ROTATE_START_EN
        s = (int'(sidx) >= CH) ? 0 : int'(sidx);
`endif
        for (int k = 0; k < CH; k++) begin
            int l;
            l = (s + k) % CH;
            sb.push_back({d[l*N +: N], SELW'(l), (k == CH - 1)});
        end
    endtask

    task automatic set_ready(int mode, int step);
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = ((step % 4) == 0) || ((step % 4) == 3);
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic run_plane(logic [CH*N-1:0] d, logic [SELW-1:0] sidx, int mode, bit garbage,
                             output int cycles);
        in_bus = d;
        start_idx = sidx;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        push_plane(d, sidx);
        cycles = 0;
        while (sb.size() > 0 && cycles < 20 * CH) begin
            set_ready(mode, cycles);
            if (garbage && $urandom_range(0, 2) == 0) begin
                load = 1'b1;
                in_bus = (CH*N)'({$urandom, $urandom});
                start_idx = SELW'($urandom);
            end
            @(posedge clk);
            #1 load = 1'b0;
            cycles++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL plane_timeout: got %0d beats left expected 0", sb.size());
            do_reset();
        end
    endtask

    logic [CH*N-1:0] d0;
    int cyc;

    initial begin
        d0 = {5'h1F, 5'h0A, 5'h03, 5'h11, 5'h07};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_plane(d0, '0, 0, 1'b0, cyc);
        check("plane_cycles", cyc, CH);
        run_plane(d0, '0, 2, 1'b0, cyc);
        run_plane(d0, '0, 1, 1'b1, cyc);
        run_plane(d0, '0, 0, 1'b1, cyc);
        check("plane_cycles_garbage", cyc, CH);

        // Reset after the second beat; the partial plane is discarded.
        in_bus = d0;
        start_idx = '0;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        push_plane(d0, '0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("beats_before_reset", sb.size(), CH - 2);
        do_reset();
        run_plane({5'h02, 5'h04, 5'h08, 5'h10, 5'h1E}, '0, 0, 1'b0, cyc);

        run_plane(d0, SELW'(3), 0, 1'b0, cyc);
        run_plane(d0, SELW'(6), 1, 1'b0, cyc);

        for (int p = 0; p < 40; p++) begin
            run_plane((CH*N)'({$urandom, $urandom}), SELW'($urandom),
                      int'($urandom_range(0, 2)), 1'(($urandom & 1)), cyc);
        end

        repeat (3) @(posedge clk);
        #1 check("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
